ps2_key_rx: RTL
===============

// Module: ps2_key_rx
// PURPOSE
//  Parametrised PS/2 keyboard receiver: samples ps2_clk/ps2_data, deframes 11-bit
//  frames (start, 8 data LSB-first, odd parity, stop), checks parity/stop, and
//  decodes set-2 prefixes (E0 extended, F0 break) into key events. Events are
//  buffered in a FWFT FIFO with valid/ready handshake. Adds a frame timeout and
//  error/overflow reporting. Sits between the PS/2 pins and the key consumer.
// PARAMETERS
//  SYNC_STAGES  2      synchroniser flops on ps2_clk and ps2_data (>=2)
//  TIMEOUT_CYC  5000   clk cycles with no ps2_clk falling edge mid-frame -> abort
//  FIFO_DEPTH   8      event FIFO entries, power of 2, >=2
//  FIFO_AW      3      log2(FIFO_DEPTH)
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          asynchronous active-low reset
//  ps2_clk      in   1          PS/2 clock pin (asynchronous)
//  ps2_data     in   1          PS/2 data pin (asynchronous)
//  evt_valid    out  1          FIFO head holds an event
//  evt_ready    in   1          consumer accepts head when evt_valid=1
//  evt_code     out  8          scan code of head event (prefixes stripped)
//  evt_brk      out  1          1 = key release (F0 seen before code)
//  evt_ext      out  1          1 = extended key (E0 seen before code)
//  fifo_count   out  FIFO_AW+1  events stored, 0..FIFO_DEPTH
//  frame_err    out  1          1-cycle pulse: parity/stop error or timeout
//  ovf          out  1          1-cycle pulse: event dropped, FIFO full
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, FSM IDLE, FIFO empty, E0/F0 flags
//    clear, synchronisers loaded with 1 (idle bus). Reset mid-frame aborts it.
//  - Falling edge = synchronised ps2_clk 1->0 seen across two clk samples; data
//    sampled from synchronised ps2_data in the same cycle the edge is detected.
//  - Frame FSM: IDLE -> (edge, data=0) DATA; edge with data=1 in IDLE ignored.
//    DATA: 8 edges shift bits LSB-first -> PARITY: store bit -> STOP: on edge,
//    frame good iff data=1 and XOR(byte,parity)=1; always return to IDLE.
//  - Bad frame: byte discarded, frame_err pulses, E0/F0 flags unchanged.
//  - Timeout: counter resets on every falling edge and in IDLE; reaching
//    TIMEOUT_CYC outside IDLE -> IDLE, frame_err pulses, partial byte dropped.
//  - Decode (cycle after good stop edge): E0 -> set ext flag; F0 -> set brk flag;
//    any other byte -> push {ext,brk,code}, then clear both flags. Prefixes alone
//    never produce events.
//  - Latency: good stop edge detected cycle N, push N+1, evt_valid=1 by N+2 if
//    FIFO was empty.
//  - FIFO: FWFT; head change only when evt_valid&evt_ready. Pop and push in the
//    same cycle both succeed, including when full; count unchanged.
//  - Push while full with no pop: event dropped, ovf pulses, contents intact.
//  - Pointers wrap modulo FIFO_DEPTH; fifo_count is registered, exact.
//  - evt_ready while evt_valid=0 has no effect.
// TESTING
//  1 Frame 0x1C (data 0,0,1,1,1,0,0,0, parity 0, stop 1) -> evt_code=1C,
//    brk=0, ext=0, evt_valid within 2 clk of stop edge, frame_err never pulses.
//  2 Frames F0,1C -> one event code=1C brk=1 ext=0; frames E0,F0,75 -> one event
//    code=75 brk=1 ext=1; no events for prefixes alone.
//  3 Frame 0x1C with parity bit 1 -> frame_err one pulse, no event; next good
//    0x1C -> normal event. Same with stop bit 0.
//  4 Stop ps2_clk after 4 data bits for TIMEOUT_CYC cycles -> frame_err pulse,
//    FSM IDLE; following good frame decoded correctly.
//  5 evt_ready=0, send FIFO_DEPTH+1 make codes -> fifo_count=FIFO_DEPTH, one ovf
//    pulse, drain yields first FIFO_DEPTH codes in order.
//  6 Assert rst_n=0 mid-frame and with FIFO non-empty -> outputs 0 immediately,
//    fifo_count=0; subsequent frame received correctly.

Source files
------------

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronises the pins, deframes 11-bit frames, folds
// set-2 E0/F0 prefixes into key events and queues them in a first-word-fall-through FIFO.
module ps2_key_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 5000,
    parameter int FIFO_DEPTH  = 8,
    parameter int FIFO_AW     = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [7:0]         evt_code,
    output logic               evt_brk,
    output logic               evt_ext,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               frame_err,
    output logic               ovf
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam int CW = FIFO_AW + 1;
    localparam logic [FIFO_AW:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   sync_clk;
    logic                   sync_data;
    logic                   falling;

    state_t                 state;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift;
    logic                   par_bit;
    logic [TW-1:0]          to_cnt;
    logic                   byte_good;
    logic [7:0]             rx_byte;

    logic                   ext_flag;
    logic                   brk_flag;
    logic                   push;

    logic [9:0]             mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]     wr_ptr;
    logic [FIFO_AW-1:0]     rd_ptr;
    logic                   full;
    logic                   pop;
    logic                   wr_en;
    logic [9:0]             head;

    assign sync_clk  = clk_sync[SYNC_STAGES-1];
    assign sync_data = data_sync[SYNC_STAGES-1];
    assign falling   = clk_prev & ~sync_clk;

    // Synchronisers reset to the idle-bus level so reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= sync_clk;
        end
    end

    // Timeout takes priority over an edge-free cycle; it only ever fires mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            frame_err <= 1'b0;
            byte_good <= 1'b0;
            rx_byte   <= '0;
        end else begin
            frame_err <= 1'b0;
            byte_good <= 1'b0;
            if (state == IDLE || falling) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
            if (state != IDLE && !falling && to_cnt == TO_LAST) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end else if (falling) begin
                case (state)
                    IDLE: begin
                        if (!sync_data) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {sync_data, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= sync_data;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (sync_data && (^shift ^ par_bit)) begin
                            byte_good <= 1'b1;
                            rx_byte   <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign push = byte_good && rx_byte != 8'hE0 && rx_byte != 8'hF0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (byte_good) begin
            if (rx_byte == 8'hE0) begin
                ext_flag <= 1'b1;
            end else if (rx_byte == 8'hF0) begin
                brk_flag <= 1'b1;
            end else begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end
        end
    end

    assign full  = (fifo_count == FULL_CNT);
    assign pop   = evt_valid & evt_ready;
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {ext_flag, brk_flag, rx_byte};
        end
    end

    // A push into a full FIFO still succeeds when the head leaves in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ovf        <= 1'b0;
        end else begin
            ovf <= push & full & ~pop;
            if (wr_en) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign evt_valid = (fifo_count != '0);
    assign head      = mem[rd_ptr];
    assign evt_code  = evt_valid ? head[7:0] : 8'h00;
    assign evt_brk   = evt_valid ? head[8] : 1'b0;
    assign evt_ext   = evt_valid ? head[9] : 1'b0;

endmodule
